// File: rtl/rv32i_multicycle_ctrl.sv
// rv32i_multicycle_ctrl: multi-cycle RV32I control FSM with fetch/data handshakes, traps and retire counter
module rv32i_multicycle_ctrl #(
  parameter int ALU_OP_W = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [31:0]         i_instr,
  input  logic                i_instr_vld,
  input  logic                i_br_less,
  input  logic                i_br_equal,
  input  logic                i_mem_ready,
  output logic                o_instr_req,
  output logic                o_pc_wren,
  output logic                o_pc_sel,
  output logic                o_rd_wren,
  output logic                o_br_un,
  output logic                o_opa_sel,
  output logic                o_opb_sel,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic                o_mem_req,
  output logic                o_mem_wren,
  output logic [1:0]          o_wb_sel,
  output logic [31:0]         o_insn,
  output logic                o_retire,
  output logic [CNT_W-1:0]    o_retire_cnt,
  output logic                o_illegal,
  output logic                o_timeout
);
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic illegal_q, illegal_d, timeout_q, timeout_d;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_r, is_i, is_ld, is_st, is_br, is_lui, is_auipc, is_jal, is_jalr, legal, taken;
  logic [3:0] arith_op, alu;
  logic instr_req, pc_wren, pc_sel, rd_wren, br_un, opa_sel, opb_sel, mem_req, mem_wren, retire;
  logic [1:0] wb_sel;
  assign opc = ir_q[6:0];
  assign f3 = ir_q[14:12];
  assign f7 = ir_q[31:25];
  assign is_r = opc == 7'b0110011;
  assign is_i = opc == 7'b0010011;
  assign is_ld = opc == 7'b0000011;
  assign is_st = opc == 7'b0100011;
  assign is_br = opc == 7'b1100011;
  assign is_lui = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign legal = is_r ? (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
    : is_i ? (f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1)
    : is_ld ? (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111)
    : is_st ? (f3 <= 3'b010)
    : is_br ? (f3 != 3'b010 && f3 != 3'b011)
    : is_jalr ? (f3 == 3'b000)
    : (is_lui || is_auipc || is_jal);
  // f7[5] only distinguishes SUB for register ops; immediate ADDI has no SUB form
  assign arith_op = f3 == 3'b000 ? {3'b000, is_r & f7[5]}
    : f3 == 3'b001 ? 4'd2
    : f3 == 3'b010 ? 4'd3
    : f3 == 3'b011 ? 4'd4
    : f3 == 3'b100 ? 4'd5
    : f3 == 3'b101 ? (f7[5] ? 4'd7 : 4'd6)
    : f3 == 3'b110 ? 4'd8 : 4'd9;
  assign taken = f3[2] ? (i_br_less ^ f3[0]) : (i_br_equal ^ f3[0]);
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    tmo_cnt_d = tmo_cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    instr_req = 1'b0;
    pc_wren = 1'b0;
    pc_sel = 1'b0;
    rd_wren = 1'b0;
    br_un = 1'b0;
    opa_sel = 1'b0;
    opb_sel = 1'b0;
    alu = 4'd0;
    mem_req = 1'b0;
    mem_wren = 1'b0;
    wb_sel = 2'd0;
    retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_req = 1'b1;
        ir_d = i_instr_vld ? i_instr : ir_q;
        state_d = i_instr_vld ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_TRAP;
        illegal_d = illegal_q | ~legal;
      end
      S_EXEC, S_MEM: begin
        alu = (is_r || is_i) ? arith_op : is_lui ? 4'd10 : 4'd0;
        opa_sel = is_auipc || is_jal || is_br;
        opb_sel = !is_r;
        br_un = is_br && f3[2:1] == 2'b11;
        if (state_q == S_EXEC) begin
          state_d = (is_ld || is_st) ? S_MEM : S_FETCH;
          tmo_cnt_d = '0;
          rd_wren = !(is_ld || is_st || is_br);
          wb_sel = (is_jal || is_jalr) ? 2'd2 : 2'd0;
          pc_wren = !(is_ld || is_st);
          pc_sel = is_jal || is_jalr || (is_br && taken);
          retire = !(is_ld || is_st);
        end else begin
          mem_req = 1'b1;
          mem_wren = is_st;
          pc_wren = i_mem_ready && is_st;
          retire = i_mem_ready && is_st;
          // ready takes priority over an expiring timeout in the same cycle
          if (i_mem_ready) state_d = is_st ? S_FETCH : S_WB;
          else if (MEM_TIMEOUT != 0 && tmo_cnt_q == TMO_LAST) begin
            state_d = S_TRAP;
            timeout_d = 1'b1;
          end else tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        rd_wren = 1'b1;
        wb_sel = 2'd1;
        pc_wren = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      ir_q <= '0;
      cnt_q <= '0;
      tmo_cnt_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      cnt_q <= cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end
  // every output is forced low while reset is held, so an aborted instruction writes nothing
  assign o_instr_req = instr_req & ~i_rst;
  assign o_pc_wren = pc_wren & ~i_rst;
  assign o_pc_sel = pc_sel & ~i_rst;
  assign o_rd_wren = rd_wren & ~i_rst;
  assign o_br_un = br_un & ~i_rst;
  assign o_opa_sel = opa_sel & ~i_rst;
  assign o_opb_sel = opb_sel & ~i_rst;
  assign o_alu_op = i_rst ? '0 : ALU_OP_W'(alu);
  assign o_mem_req = mem_req & ~i_rst;
  assign o_mem_wren = mem_wren & ~i_rst;
  assign o_wb_sel = i_rst ? 2'd0 : wb_sel;
  assign o_insn = i_rst ? 32'd0 : ir_q;
  assign o_retire = retire & ~i_rst;
  assign o_retire_cnt = i_rst ? '0 : cnt_q;
  assign o_illegal = illegal_q & ~i_rst;
  assign o_timeout = timeout_q & ~i_rst;
endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with valid/ready handshakes to instruction and data memory.
- Latches the instruction internally and drives datapath controls per state.
- Adds a memory-timeout trap, an illegal-instruction trap, and a parametrised retired-instruction counter.

Parameters:
- ALU_OP_W, 4, width of o_alu_op; must be >= 4.
- MEM_TIMEOUT, 16, max cycles waiting for i_mem_ready before trap; 0 disables the timeout.
- CNT_W, 32, width of o_retire_cnt.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_instr  in  32  instruction word from instruction memory
- i_instr_vld  in  1  i_instr valid; completes fetch handshake
- i_br_less  in  1  comparator rs1<rs2 (signedness per o_br_un)
- i_br_equal  in  1  comparator rs1==rs2
- i_mem_ready  in  1  data memory accepted or completed access
- o_instr_req  out  1  fetch request
- o_pc_wren  out  1  PC register update this cycle
- o_pc_sel  out  1  0=PC+4, 1=ALU result
- o_rd_wren  out  1  register file write
- o_br_un  out  1  unsigned compare (BLTU/BGEU)
- o_opa_sel  out  1  0=rs1, 1=PC
- o_opb_sel  out  1  0=rs2, 1=imm
- o_alu_op  out  ALU_OP_W  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
- o_mem_req  out  1  data access request
- o_mem_wren  out  1  store (valid with o_mem_req)
- o_wb_sel  out  2  0=ALU, 1=MEM, 2=PC+4
- o_insn  out  32  latched instruction register (for immediate generation)
- o_retire  out  1  one-cycle pulse per completed instruction
- o_retire_cnt  out  CNT_W  retired count, wraps modulo 2^CNT_W
- o_illegal  out  1  sticky: illegal-instruction trap
- o_timeout  out  1  sticky: memory-timeout trap

Behaviour:
- Reset: state=FETCH, IR=0, counter=0, timeout count=0, traps=0.
  - All outputs 0 during the reset cycle.
  - o_instr_req=1 from the first cycle after reset.
- Outputs are decoded combinationally from state + IR; all state is registered on i_clk.
- FETCH:
  - o_instr_req=1.
  - On i_instr_vld, IR<=i_instr and go to DECODE; otherwise hold.
- DECODE (1 cycle):
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111.
  - The funct3/funct7 combination must also be legal: R-type funct7 in {0000000, 0100000}, with 0100000 only for ADD/SUB and SRL/SRA.
  - Illegal: go to TRAP and set o_illegal. Otherwise go to EXEC.
- EXEC (1 cycle), per type:
  - R / I-ALU / LUI / AUIPC: o_rd_wren=1, o_wb_sel=0, o_pc_wren=1, o_pc_sel=0, retire, go to FETCH.
    - LUI: PASSB with opb=imm.
    - AUIPC: ADD with opa=PC, opb=imm.
  - JAL / JALR: ADD with opb=imm (opa=PC for JAL, rs1 for JALR); o_rd_wren=1, o_wb_sel=2, o_pc_wren=1, o_pc_sel=1, retire, go to FETCH.
  - Branch:
    - opa=PC, opb=imm, ADD, o_pc_wren=1.
    - o_br_un=1 for funct3 110/111.
    - o_pc_sel=1 iff taken (BEQ eq, BNE !eq, BLT/BLTU less, BGE/BGEU !less).
    - Retire, go to FETCH.
  - Load / store: ADD with opb=imm; go to MEM.
- MEM:
  - o_mem_req=1; o_mem_wren=1 for stores.
  - ALU controls held as in EXEC.
  - On i_mem_ready:
    - Store: o_pc_wren=1, retire, go to FETCH.
    - Load: go to WB.
  - Each waiting cycle increments the timeout count. When the count equals MEM_TIMEOUT-1 with no ready (i.e. MEM_TIMEOUT cycles without ready), go to TRAP and set o_timeout.
  - If ready and timeout coincide, ready wins.
  - The count is cleared on MEM entry.
- WB (1 cycle, loads only): o_rd_wren=1, o_wb_sel=1, o_pc_wren=1, o_pc_sel=0, retire, go to FETCH.
- TRAP:
  - All request and write-enable outputs are 0.
  - Held until i_rst.
- Latency with ready/valid asserted immediately:
  - ALU, jump and branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- o_retire_cnt increments in the same cycle o_retire=1; all-ones wraps to 0.
- Reset mid-instruction aborts the instruction with no write; the next cycle is FETCH.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), vld immediate -> EXEC cycle 3: o_rd_wren=1, o_alu_op=0, o_wb_sel=0, o_pc_sel=0; o_retire_cnt 0->1.
- BEQ x0,x0 (0x00000063): i_br_equal=1 -> o_pc_sel=1, o_pc_wren=1. Same instruction with i_br_equal=0 -> o_pc_sel=0.
- LW x5,0(x1) (0x0000A283), i_mem_ready after 3 wait cycles -> o_mem_req high 4 cycles, o_mem_wren=0, then WB with o_wb_sel=1, o_rd_wren=1; 8 cycles total.
- SW x2,4(x1) (0x0020A223), MEM_TIMEOUT=16, ready never asserted -> o_timeout=1 after 16 MEM cycles; o_mem_req=0 thereafter; counter unchanged.
- i_instr=0x00000000 -> o_illegal=1 after DECODE, o_instr_req stays 0. Then i_rst for 1 cycle -> FETCH, o_illegal=0, o_retire_cnt=0.
- CNT_W=4, 16 consecutive ADDs -> o_retire_cnt wraps to 0; a reset asserted during a MEM wait -> no o_rd_wren and no o_retire.
